// File: rtl/pixel_frame_loader.sv
// rtl/pixel_frame_loader.sv - RGB pixel stream to grayscale frame buffer with frame_valid/frame_ack publish
// Accepts one pixel per handshake in raster order, holds a full frame until the consumer acks it.
module pixel_frame_loader #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = 8,
  localparam int RW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W),
  localparam int AW = $clog2(IMG_W * IMG_H)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [PIX_W-1:0] s_r_i,
  input  logic [PIX_W-1:0] s_g_i,
  input  logic [PIX_W-1:0] s_b_i,
  input  logic             s_last_i,
  input  logic [RW-1:0]    rd_row_i,
  input  logic [CW-1:0]    rd_col_i,
  output logic [PIX_W-1:0] rd_data_o,
  output logic             frame_valid_o,
  output logic [3:0]       frame_id_o,
  input  logic             frame_ack_i,
  output logic             frame_err_o
);

  typedef enum logic [1:0] {FILL, DONE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [3:0]      id_q, id_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic [PIX_W-1:0] rd_data_q;

  logic [PIX_W-1:0] mem [IMG_W*IMG_H];

  logic             accept;
  logic             last_pix;
  logic [PIX_W+1:0] sum;
  logic [PIX_W+1:0] quot;
  logic [PIX_W-1:0] gray;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  assign s_ready_o     = ready_q & ~rst_i;
  assign accept        = s_valid_i & s_ready_o;
  assign last_pix      = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  assign sum           = {2'b00, s_r_i} + {2'b00, s_g_i} + {2'b00, s_b_i};
  assign quot          = sum / (PIX_W+2)'(3);
  assign gray          = quot[PIX_W-1:0];
  assign wr_addr       = AW'(row_q) * AW'(IMG_W) + AW'(col_q);
  assign rd_addr       = AW'(rd_row_i) * AW'(IMG_W) + AW'(rd_col_i);
  assign rd_data_o     = rd_data_q;
  assign frame_valid_o = (state_q == HOLD);
  assign frame_id_o    = id_q;
  assign frame_err_o   = err_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    id_d    = id_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (last_pix) begin
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
            err_d   = ~s_last_i;
          end else if (s_last_i) begin
            row_d = '0;
            col_d = '0;
            err_d = 1'b1;
          end else if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = HOLD;
        id_d    = id_q + 4'd1;
      end
      HOLD: begin
        if (frame_ack_i) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    // Ready lags a return to FILL by one cycle and drops on the edge that completes a frame.
    ready_d = (state_q == FILL) && (state_d == FILL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      row_q     <= '0;
      col_q     <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      id_q      <= id_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      rd_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_addr] <= gray;
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// tb/tb_pixel_frame_loader.sv - directed self-checking bench for pixel_frame_loader
module tb_pixel_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_r = '0, s_g = '0, s_b = '0;
  logic       s_last = 1'b0;
  logic [4:0] rd_row = '0, rd_col = '0;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [3:0] frame_id;
  logic       frame_ack = 1'b0;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;

  pixel_frame_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_r_i        (s_r),
    .s_g_i        (s_g),
    .s_b_i        (s_b),
    .s_last_i     (s_last),
    .rd_row_i     (rd_row),
    .rd_col_i     (rd_col),
    .rd_data_o    (rd_data),
    .frame_valid_o(frame_valid),
    .frame_id_o   (frame_id),
    .frame_ack_i  (frame_ack),
    .frame_err_o  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic last, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 1) == 1) begin
      s_valid = 1'b0;
      step();
    end
    s_r = r; s_g = g; s_b = b; s_last = last; s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (s_ready !== 1'b1) chk("ready_timeout", s_ready, 1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int from, input int to, input int last_at, input bit gaps);
    logic [7:0] r, g, b;
    for (int k = from; k <= to; k++) begin
      case (mode)
        0: begin r = 8'(k % 256); g = r; b = r; end
        1: begin r = 8'd10; g = 8'd20; b = 8'd31; end
        2: begin r = 8'(k % 256); g = 8'd0; b = 8'd0; end
        3: begin r = 8'(k % 256); g = 8'((k * 3) % 256); b = 8'd0; end
        default: begin r = 8'd99; g = 8'd99; b = 8'd99; end
      endcase
      send_px(r, g, b, k == last_at, gaps);
    end
  endtask

  task automatic rd(input string tag, input int row, input int col, input logic [7:0] exp);
    rd_row = 5'(row);
    rd_col = 5'(col);
    step();
    chk(tag, rd_data, exp);
  endtask

  task automatic wait_publish(input string tag);
    chk({tag, "_fv_early"}, frame_valid, 0);
    chk({tag, "_ready_off"}, s_ready, 0);
    step();
    chk({tag, "_fv"}, frame_valid, 1);
  endtask

  task automatic do_ack(input string tag);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk({tag, "_fv_drop"}, frame_valid, 0);
    chk({tag, "_ready_lag"}, s_ready, 0);
    step();
    chk({tag, "_ready_back"}, s_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int e0;
    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", s_ready, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_id", frame_id, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_rd", rd_data, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", s_ready, 1);

    // Gray ramp frame
    send_frame(0, 0, 1023, 1023, 0);
    wait_publish("t1");
    chk("t1_id", frame_id, 1);
    rd("t1_0_5", 0, 5, 8'd5);
    rd("t1_31_31", 31, 31, 8'd255);
    rd("t1_2_3", 2, 3, 8'd67);
    chk("t1_no_err", err_cnt, 0);
    do_ack("t1");

    // Constant colour with random gaps
    send_frame(1, 0, 1023, 1023, 1);
    wait_publish("t2");
    chk("t2_id", frame_id, 2);
    for (int i = 0; i < 6; i++) rd("t2_rd", $urandom_range(0, 31), $urandom_range(0, 31), 8'd20);
    s_r = 8'd0; s_g = 8'd0; s_b = 8'd0; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_ready", s_ready, 0);
    end
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    s_valid = 1'b0;
    chk("t2_ack_ready", s_ready, 0);
    rd("t2_no_write", 0, 0, 8'd20);
    chk("t2_no_err", err_cnt, 0);

    // Early s_last then a full frame
    do_reset();
    e0 = err_cnt;
    send_frame(4, 0, 100, 100, 0);
    chk("t3_err_pulse", frame_err, 1);
    step();
    chk("t3_err_end", frame_err, 0);
    chk("t3_fv_none", frame_valid, 0);
    chk("t3_ready", s_ready, 1);
    send_frame(0, 0, 1022, -1, 0);
    chk("t3_fv_before_last", frame_valid, 0);
    send_frame(0, 1023, 1023, 1023, 0);
    wait_publish("t3");
    chk("t3_id", frame_id, 1);
    chk("t3_err_count", err_cnt - e0, 1);
    rd("t3_overwrite", 3, 4, 8'd100);
    do_ack("t3");

    // Missing s_last
    e0 = err_cnt;
    send_frame(2, 0, 1023, -1, 0);
    wait_publish("t4");
    chk("t4_id", frame_id, 2);
    chk("t4_err_count", err_cnt - e0, 1);
    rd("t4_2_3", 2, 3, 8'd22);
    rd("t4_31_31", 31, 31, 8'd85);
    do_ack("t4");

    // frame_id wrap over 17 frames
    do_reset();
    for (int f = 1; f <= 17; f++) begin
      send_frame(4, 0, 1023, 1023, 0);
      wait_publish("t5");
      chk("t5_id", frame_id, 32'(f % 16));
      do_ack("t5");
    end

    // Reset mid-frame
    do_reset();
    send_frame(4, 0, 499, -1, 0);
    rst = 1'b1;
    step();
    chk("t6_rst_fv", frame_valid, 0);
    chk("t6_rst_ready", s_ready, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_post_fv", frame_valid, 0);
    send_frame(3, 0, 1023, 1023, 0);
    wait_publish("t6");
    chk("t6_id", frame_id, 1);
    rd("t6_0_0", 0, 0, 8'd0);
    rd("t6_15_20", 15, 20, 8'd154);
    rd("t6_0_5", 0, 5, 8'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Write side of the classifier's image interface: accepts an RGB pixel stream over a valid/ready handshake and converts each pixel to grayscale.
- Stores the frame in a 32x32 grayscale buffer, then publishes it to the CNN core through a synchronous read port and a frame_valid/frame_ack handshake.
- Replaces file-based image loading, so frames can be streamed in from a host or DMA interface.

Parameters:
- IMG_W, 32, pixels per row
- IMG_H, 32, rows per frame
- PIX_W, 8, bits per colour channel and per grayscale pixel

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  loader can accept a pixel
- s_r, s_g, s_b  in  PIX_W each  pixel channels, unsigned
- s_last  in  1  marks the final pixel of a frame
- rd_row  in  5  read row index (log2 IMG_H)
- rd_col  in  5  read column index (log2 IMG_W)
- rd_data  out  PIX_W  grayscale pixel at (rd_row, rd_col); 1-cycle latency
- frame_valid  out  1  a complete frame is held and readable
- frame_id  out  4  sequence number of the published frame
- frame_ack  in  1  consumer releases the frame
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset values:
  - s_ready=0 during rst, 1 the cycle after.
  - frame_valid=0, frame_id=0, frame_err=0, rd_data=0.
  - Pixel counter row=col=0; state FILL.
  - Buffer contents are not cleared.
- Transfer: a pixel is accepted on a clk edge with s_valid && s_ready. No other cycle changes the counters.
- Grayscale conversion: gray = floor((r+g+b)/3).
  - The sum is computed at PIX_W+2 bits, so it cannot overflow; the result fits PIX_W.
  - Example: (255,255,255)->255, (1,1,0)->0, (10,20,31)->20.
- Write order: raster order, col increments first. At col=IMG_W-1, col wraps to 0 and row increments. Pixel k is written to row k/IMG_W, col k%IMG_W.
- State FILL: s_ready=1.
  - An accepted pixel at index IMG_W*IMG_H-1 (1023) completes the frame and moves the loader to HOLD on the next edge.
  - Early s_last (accepted on index <1023): frame_err pulses one cycle, the partial frame is discarded, counters reset to 0, and the loader stays in FILL. Buffer cells already written are overwritten by the next frame.
  - Missing s_last (index 1023 accepted with s_last=0): frame_err pulses one cycle, but the frame is still published.
- State HOLD:
  - s_ready=0 and frame_valid=1.
  - frame_id holds the count of frames published since reset, mod 16. It increments by 1 on entry to HOLD and wraps 15->0.
- frame_ack:
  - In HOLD, frame_ack=1 returns the loader to FILL on the next edge. frame_valid drops that edge, and s_ready=1 the following cycle.
  - frame_ack in FILL is ignored.
- Read port:
  - rd_data is registered: the address presented at edge n gives data after edge n.
  - The port is active in both states. Reads during FILL return the current buffer contents and are not guaranteed coherent.
  - Buffer writes and reads to the same cell in the same cycle return the old value.
- Reset mid-frame: in-flight pixels are dropped, counters zero, and the loader is in FILL. A held frame is lost (frame_valid=0).
- Simultaneous events: rst has priority over all. frame_ack and s_valid together in HOLD: s_valid is not accepted that cycle, because s_ready=0.
- No combinational path from s_valid to s_ready; s_ready depends only on state.
- Buffer: IMG_W*IMG_H x PIX_W single-write/single-read memory, inferable as block RAM.

Test Plan:
- Reset, then stream 1024 pixels with r=g=b=k%256 and s_last on pixel 1023 -> frame_valid=1 two edges after the last acceptance; frame_id=1; read (0,5)=5, (31,31)=255; frame_err never pulses.
- Stream 1024 pixels of (10,20,31), toggling s_valid randomly -> every read returns 20; s_ready=0 while frame_valid=1; extra pixels presented in HOLD are not accepted.
- Assert s_last on pixel 100, then send a full correct frame -> one frame_err pulse at the edge after pixel 100; the first frame_valid arrives only after the subsequent 1024 pixels; frame_id=1.
- Send 1024 pixels without s_last -> frame_err pulses once; frame_valid=1; data correct.
- Run 17 frames, each followed by frame_ack -> frame_id sequence 1..15, 0, 1; s_ready returns 1 exactly one cycle after frame_valid falls.
- Assert rst after 500 accepted pixels, then send a full frame -> frame_valid=0 during and after reset; the new frame is published with frame_id=1 and correct contents at (0,0) and (15,20).
